lcd_frame_writer: RTL and testbench

Parametrised successor to the fixed 16x2 LCD sequencer: drives an HD44780-class character LCD of ROWS x COLS through the existing byte-level write engine (ena_write / done_write handshake). It runs the power-on init sequence once, then writes full frames of text on request or on an optional periodic refresh. It applies a longer settle delay after the clear command, and supports re-writing without re-initialising. It sits between application text sources and the I2C/4-bit write engine.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_us_timer.sv | 22 ++
 rtl/lcd_frame_writer.sv | 168 ++++++++++++++++
 tb/tb_lcd_frame_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD frame writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_WRITE,
    ST_DELAY,
    ST_READY
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNC_4BIT  = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC_2LINE = 8'h28;
  localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM  = 8'h80;

  localparam int INIT_LEN = 5;

  // Rows 2/3 continue the DDRAM lines of rows 0/1, offset by one row width.
  function automatic logic [7:0] lcd_row_addr(input int r, input int cols);
    int off;
    off = (r & 1) * 'h40 + (r >> 1) * cols;
    return LCD_CMD_SET_DDRAM | off[7:0];
  endfunction

endpackage

// File: rtl/lcd_us_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module lcd_us_timer #(
  parameter int W = 8
) (
  input  logic         clk_1MHz,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n)            r_cnt <= '0;
    else if (i_load)       r_cnt <= i_val;
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a ROWS x COLS character LCD through the byte write engine:
// one-time init, then full-frame writes on request or periodic refresh.
module lcd_frame_writer import lcd_pkg::*; #(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int DELAY_US       = 50,
  parameter int CLEAR_DELAY_US = 2000,
  parameter int AUTO_REFRESH   = 0,
  parameter int REFRESH_US     = 100000
) (
  input  logic                 clk_1MHz,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 update,
  input  logic [ROWS*COLS*8-1:0] text,
  input  logic                 done_write,
  output logic [7:0]           data,
  output logic                 cmd_data,
  output logic                 ena_write,
  output logic                 busy,
  output logic                 ready
);

  localparam int NCH  = ROWS * COLS;
  localparam int CW   = $clog2(NCH);
  localparam int TMAX = (CLEAR_DELAY_US > REFRESH_US) ? CLEAR_DELAY_US : REFRESH_US;
  localparam int TW   = $clog2(TMAX + 1);

  lcd_state_e             r_state, w_next;
  logic                   r_init;
  logic [2:0]             r_istep;
  logic [2:0]             r_row;
  logic [5:0]             r_col;   // 0 = row address command, 1..COLS = characters
  logic                   r_pending;
  logic [NCH-1:0][7:0]    r_shadow;
  logic [7:0]             r_data;
  logic                   r_cmd;
  logic                   r_ena_write;

  logic                   w_last, w_frame_start;
  logic                   w_tmr_load, w_tmr_done;
  logic [TW-1:0]          w_tmr_val;
  logic [7:0]             w_byte;
  logic                   w_byte_cmd;
  logic [CW-1:0]          w_char_sel;

  assign w_last        = !r_init && (r_row == 3'(ROWS-1)) && (r_col == 6'(COLS));
  assign w_frame_start = !r_init && (r_row == 3'd0) && (r_col == 6'd0);
  // First character of the frame lives in the top byte of text.
  assign w_char_sel    = CW'(NCH - int'(r_row) * COLS - int'(r_col));

  always_comb begin
    w_byte     = 8'h00;
    w_byte_cmd = 1'b0;
    if (r_init) begin
      unique case (r_istep)
        3'd0:    w_byte = LCD_CMD_FUNC_4BIT;
        3'd1:    w_byte = LCD_CMD_FUNC_2LINE;
        3'd2:    w_byte = LCD_CMD_DISP_ON;
        3'd3:    w_byte = LCD_CMD_ENTRY_INC;
        default: w_byte = LCD_CMD_CLEAR;
      endcase
    end else if (r_col == 6'd0) begin
      w_byte = lcd_row_addr(int'(r_row), COLS);
    end else begin
      w_byte     = r_shadow[w_char_sel];
      w_byte_cmd = 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    unique case (r_state)
      ST_IDLE:       if (ena) w_next = ST_LOAD;
      ST_LOAD:       w_next = ST_ISSUE;
      ST_ISSUE:      w_next = ST_WAIT_WRITE;
      ST_WAIT_WRITE: if (done_write) begin
        w_next     = ST_DELAY;
        w_tmr_load = 1'b1;
        w_tmr_val  = (!r_cmd && r_data == LCD_CMD_CLEAR) ? TW'(CLEAR_DELAY_US - 1)
                                                         : TW'(DELAY_US - 1);
      end
      ST_DELAY:      if (w_tmr_done) begin
        if (w_last) begin
          // READY lasts REFRESH_US counted cycles plus the expiry cycle.
          w_next     = ST_READY;
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(REFRESH_US);
        end else begin
          w_next = ST_LOAD;
        end
      end
      ST_READY:      if (update || r_pending || (AUTO_REFRESH != 0 && w_tmr_done))
                       w_next = ST_LOAD;
      default:       w_next = ST_IDLE;
    endcase
  end

  lcd_us_timer #(.W(TW)) u_timer (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .i_load   (w_tmr_load),
    .i_val    (w_tmr_val),
    .o_done   (w_tmr_done)
  );

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_init      <= 1'b0;
      r_istep     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_data      <= 8'h00;
      r_cmd       <= 1'b0;
      r_ena_write <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ena_write <= (r_state == ST_ISSUE);
      case (r_state)
        ST_IDLE: if (ena) begin
          r_init  <= 1'b1;
          r_istep <= '0;
        end
        ST_LOAD: begin
          r_data <= w_byte;
          r_cmd  <= w_byte_cmd;
          if (w_frame_start) r_shadow <= text;
        end
        ST_DELAY: if (w_tmr_done && !w_last) begin
          if (r_init) begin
            if (r_istep == 3'(INIT_LEN-1)) begin
              r_init <= 1'b0;
              r_row  <= '0;
              r_col  <= '0;
            end else begin
              r_istep <= r_istep + 1'b1;
            end
          end else if (r_col == 6'(COLS)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        ST_READY: if (w_next == ST_LOAD) begin
          r_init <= 1'b0;
          r_row  <= '0;
          r_col  <= '0;
        end
        default: ;
      endcase
      if (r_state == ST_READY && w_next == ST_LOAD) r_pending <= 1'b0;
      else if (update && busy)                      r_pending <= 1'b1;
    end
  end

  assign data      = r_data;
  assign cmd_data  = r_cmd;
  assign ena_write = r_ena_write;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_READY);
  assign ready     = (r_state == ST_READY);

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Random-text bench: two writer configurations against a queue-based model
// of the byte stream, handshake latencies and refresh period.
module tb_lcd_frame_writer;

  typedef logic [8:0] q9_t[$];

  logic clk_1MHz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_1MHz = ~clk_1MHz;

  int cyc = 0;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // DUT A: default 2x16 display
  logic         a_ena, a_update, a_done, a_cmd, a_ew, a_busy, a_ready;
  logic [255:0] a_text;
  logic [7:0]   a_data;
  // DUT B: 4x20, short delays, auto refresh
  logic         b_ena, b_update, b_done, b_cmd, b_ew, b_busy, b_ready;
  logic [639:0] b_text;
  logic [7:0]   b_data;

  lcd_frame_writer u_a (
    .clk_1MHz (clk_1MHz), .rst_n (rst_n), .ena (a_ena), .update (a_update),
    .text (a_text), .done_write (a_done), .data (a_data), .cmd_data (a_cmd),
    .ena_write (a_ew), .busy (a_busy), .ready (a_ready)
  );

  lcd_frame_writer #(
    .ROWS (4), .COLS (20), .DELAY_US (4), .CLEAR_DELAY_US (30),
    .AUTO_REFRESH (1), .REFRESH_US (1000)
  ) u_b (
    .clk_1MHz (clk_1MHz), .rst_n (rst_n), .ena (b_ena), .update (b_update),
    .text (b_text), .done_write (b_done), .data (b_data), .cmd_data (b_cmd),
    .ena_write (b_ew), .busy (b_busy), .ready (b_ready)
  );

  // Write-engine stand-ins: done_write three cycles after each ena_write.
  logic [2:0] a_sh, b_sh;
  always @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
    end else begin
      a_sh <= {a_sh[1:0], a_ew};
      b_sh <= {b_sh[1:0], b_ew};
    end
  end
  assign a_done = a_sh[2];
  assign b_done = b_sh[2];

  q9_t a_q, b_q;
  int  a_et[$], a_dt[$];
  always @(negedge clk_1MHz) begin
    if (a_ew) begin
      a_q.push_back({a_cmd, a_data});
      a_et.push_back(cyc);
    end
    if (a_done) a_dt.push_back(cyc);
    if (b_ew) b_q.push_back({b_cmd, b_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected byte stream, {cmd_data, data}, built straight from the display rules.
  function automatic q9_t model(input int rows, input int cols,
                                input logic [639:0] txt, input bit with_init);
    q9_t q;
    logic [7:0] init_b[5] = '{8'h02, 8'h28, 8'h0C, 8'h06, 8'h01};
    if (with_init) foreach (init_b[i]) q.push_back({1'b0, init_b[i]});
    for (int r = 0; r < rows; r++) begin
      q.push_back({1'b0, 8'(128 + (r % 2) * 64 + (r / 2) * cols)});
      for (int c = 0; c < cols; c++) begin
        int k = rows * cols - 1 - (r * cols + c);
        q.push_back({1'b1, txt[k*8 +: 8]});
      end
    end
    return q;
  endfunction

  task automatic cmp_q(input string tag, input q9_t got, input q9_t exp);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return a_ready;
      1:       return a_busy;
      2:       return b_ready;
      default: return b_busy;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input int lim);
    int n = 0;
    while (sig(which) !== 1'b1 && n < lim) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (n >= lim) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_bytes(input string tag, input int cnt, input int lim);
    int n = 0;
    while (a_q.size() < cnt && n < lim) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (n >= lim) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic rnd_text(output logic [639:0] t);
    for (int i = 0; i < 20; i++) t[i*32 +: 32] = $urandom;
  endtask

  task automatic pulse_a_update();
    a_update = 1'b1;
    @(negedge clk_1MHz);
    a_update = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    logic [639:0] t1, t2, t3, t4, bt;
    q9_t e;
    int start, t_r, n;
    a_ena = 0; a_update = 0; a_text = '0;
    b_ena = 0; b_update = 0; b_text = '0;

    repeat (3) @(negedge clk_1MHz);
    chk("rst_data", a_data, 0);
    chk("rst_cmd", a_cmd, 0);
    chk("rst_ew", a_ew, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_ready, 0);
    rst_n = 1'b1;
    @(negedge clk_1MHz);

    // init plus first frame
    rnd_text(t1);
    a_text = t1[255:0];
    start  = cyc;
    a_ena  = 1'b1;
    @(negedge clk_1MHz);
    a_ena  = 1'b0;
    wait_sig("init_ready", 0, 20000);
    cmp_q("init", a_q, model(2, 16, {384'b0, t1[255:0]}, 1));
    chk("init_ready", a_ready, 1);
    chk("init_busy", a_busy, 0);
    if (a_et.size() > 0) chk("ena_lat", a_et[0] - start, 3);
    for (int i = 1; i < a_et.size() && i <= a_dt.size() && i < a_q.size(); i++)
      chk($sformatf("gap%0d", i), a_et[i] - (a_dt[i-1] + 1),
          (a_q[i-1] == 9'h001) ? 2002 : 52);
    a_q.delete(); a_et.delete(); a_dt.delete();

    // rewrite from READY, no init
    rnd_text(t2);
    a_text = t2[255:0];
    pulse_a_update();
    wait_sig("upd_ready", 0, 10000);
    cmp_q("upd", a_q, model(2, 16, {384'b0, t2[255:0]}, 0));
    a_q.delete();

    // two updates mid-frame collapse into one frame with the new text
    rnd_text(t3);
    rnd_text(t4);
    a_text = t3[255:0];
    pulse_a_update();
    wait_bytes("mid", 10, 5000);
    a_text = t4[255:0];
    pulse_a_update();
    repeat (20) @(negedge clk_1MHz);
    pulse_a_update();
    wait_bytes("pend", 68, 20000);
    wait_sig("pend_ready", 0, 1000);
    repeat (500) @(negedge clk_1MHz);
    e = model(2, 16, {384'b0, t3[255:0]}, 0);
    e = {e, model(2, 16, {384'b0, t4[255:0]}, 0)};
    cmp_q("pend", a_q, e);
    chk("pend_ready", a_ready, 1);

    // async reset while waiting on the write engine
    a_q.delete();
    pulse_a_update();
    n = 0;
    while (a_ew !== 1'b1 && n < 100) begin
      @(negedge clk_1MHz);
      n++;
    end
    if (n >= 100) chk("ww_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", a_data, 0);
    chk("arst_cmd", a_cmd, 0);
    chk("arst_ew", a_ew, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_ready", a_ready, 0);
    repeat (2) @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
    a_q.delete();
    pulse_a_update();
    repeat (20) @(negedge clk_1MHz);
    chk("idle_upd_busy", a_busy, 0);
    chk("idle_upd_bytes", a_q.size(), 0);
    a_ena = 1'b1;
    @(negedge clk_1MHz);
    a_ena = 1'b0;
    wait_bytes("restart", 1, 100);
    if (a_q.size() > 0) chk("restart_b0", 32'(a_q[0]), 32'h002);

    // 4x20 display with auto refresh
    rnd_text(bt);
    b_text = bt;
    b_ena  = 1'b1;
    @(negedge clk_1MHz);
    b_ena  = 1'b0;
    wait_sig("b_ready", 2, 20000);
    t_r = cyc;
    cmp_q("b_init", b_q, model(4, 20, bt, 1));
    if (b_q.size() > 68) begin
      chk("b_row0", 32'(b_q[5]), 32'h080);
      chk("b_row1", 32'(b_q[26]), 32'h0C0);
      chk("b_row2", 32'(b_q[47]), 32'h094);
      chk("b_row3", 32'(b_q[68]), 32'h0D4);
    end
    b_q.delete();
    wait_sig("b_refresh", 3, 3000);
    chk("refresh_lat", cyc - t_r, 1001);
    wait_sig("b_ref_ready", 2, 5000);
    cmp_q("b_ref", b_q, model(4, 20, bt, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
